// File: rtl/register_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter and its round-robin core.
package register_write_arbiter_pkg;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   localparam int DEF_BITS       = 32;
   localparam int DEF_REGISTERS  = 16;
   localparam int DEF_REQUESTERS = 4;

   // Index width for n entries; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/register_write_arbiter_if.sv
// Requester-side bus and register-file strobes of the write arbiter.
interface register_write_arbiter_if
   import register_write_arbiter_pkg::*;
#(
   parameter int BITS       = DEF_BITS,
   parameter int REGISTERS  = DEF_REGISTERS,
   parameter int REQUESTERS = DEF_REQUESTERS,
   parameter int IDXW       = idx_width(REGISTERS)
);
   logic                         freeze;
   logic [REQUESTERS-1:0]        req;
   logic [REQUESTERS-1:0]        req_clr;
   logic [REQUESTERS*IDXW-1:0]   req_idx;
   logic [REQUESTERS*BITS-1:0]   req_data;
   logic [REQUESTERS-1:0]        ack;
   logic [REQUESTERS-1:0]        err;
   logic [BITS-1:0]              wr_data;
   logic [REGISTERS-1:0]         load_enable;
   logic [REGISTERS-1:0]         reg_clr;
   logic                         busy;

   modport master (
      output freeze, req, req_clr, req_idx, req_data,
      input  ack, err, wr_data, load_enable, reg_clr, busy
   );

   modport slave (
      input  freeze, req, req_clr, req_idx, req_data,
      output ack, err, wr_data, load_enable, reg_clr, busy
   );
endinterface

// File: rtl/register_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr, wrapping.
module rr_arbiter
   import register_write_arbiter_pkg::*;
#(
   parameter int N  = DEF_REQUESTERS,
   parameter int PW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] win,
   output logic          any
);
   logic [N-1:0] elig;
   int           j;

   assign elig = req & ~mask;

   always_comb begin
      grant = '0;
      win   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && elig[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            win      = PW'(j);
         end
      end
   end
endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin owner of the register file write port; one clear-all after reset, then one write per cycle.
module register_write_arbiter
   import register_write_arbiter_pkg::*;
#(
   parameter int BITS       = DEF_BITS,
   parameter int REGISTERS  = DEF_REGISTERS,
   parameter int REQUESTERS = DEF_REQUESTERS,
   parameter int IDXW       = idx_width(REGISTERS)
) (
   input logic                  clk,
   input logic                  clr_n,
   register_write_arbiter_if.slave bus
);
   localparam int PW = idx_width(REQUESTERS);

   state_t                state;
   logic [PW-1:0]         ptr;
   logic [PW-1:0]         win;
   logic [REQUESTERS-1:0] mask;
   logic [REQUESTERS-1:0] grant;
   logic [REQUESTERS-1:0] req_gated;
   logic                  any;

   logic [REQUESTERS-1:0] ack_q;
   logic [REQUESTERS-1:0] err_q;
   logic [BITS-1:0]       wr_q;
   logic [REGISTERS-1:0]  le_q;
   logic [REGISTERS-1:0]  rc_q;
   logic                  busy_q;

   logic [IDXW-1:0]       w_idx;
   logic [BITS-1:0]       w_data;
   logic                  w_clr;
   logic                  w_valid;
   logic [REGISTERS-1:0]  strobe;

   // No grants while initialising or frozen.
   assign req_gated = bus.req & {REQUESTERS{(state == RUN) && !bus.freeze}};

   rr_arbiter #(.N(REQUESTERS), .PW(PW)) u_rr (
      .req   (req_gated),
      .mask  (mask),
      .ptr   (ptr),
      .grant (grant),
      .win   (win),
      .any   (any)
   );

   assign w_idx   = bus.req_idx[int'(win)*IDXW +: IDXW];
   assign w_data  = bus.req_data[int'(win)*BITS +: BITS];
   assign w_clr   = bus.req_clr[win];
   assign w_valid = int'(w_idx) < REGISTERS;

   always_comb begin
      strobe = '0;
      if (w_valid) strobe[w_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state  <= INIT;
         ptr    <= '0;
         mask   <= '0;
         ack_q  <= '0;
         err_q  <= '0;
         wr_q   <= '0;
         le_q   <= '0;
         rc_q   <= '0;
         busy_q <= 1'b1;
      end else begin
         ack_q <= '0;
         err_q <= '0;
         le_q  <= '0;
         rc_q  <= '0;
         // Mask only ever covers the cycle right after a grant.
         mask  <= '0;
         case (state)
            INIT: begin
               rc_q   <= '1;
               busy_q <= 1'b1;
               state  <= RUN;
            end
            RUN: begin
               busy_q <= 1'b0;
               if (any) begin
                  ack_q <= grant;
                  mask  <= grant;
                  ptr   <= (win == PW'(REQUESTERS-1)) ? '0 : win + 1'b1;
                  if (!w_valid) begin
                     err_q <= grant;
                  end else if (w_clr) begin
                     rc_q <= strobe;
                  end else begin
                     le_q <= strobe;
                     wr_q <= w_data;
                  end
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   assign bus.ack         = ack_q;
   assign bus.err         = err_q;
   assign bus.wr_data     = wr_q;
   assign bus.load_enable = le_q;
   assign bus.reg_clr     = rc_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_register_write_arbiter.sv
// Drives a 16-register and a 12-register arbiter with identical traffic and checks both against a queue-free model.
module tb_register_write_arbiter;
   logic clk;
   logic clr_n;

   logic         freeze;
   logic [3:0]   req, req_clr;
   logic [15:0]  req_idx;
   logic [127:0] req_data;

   register_write_arbiter_if #(.BITS(32), .REGISTERS(16), .REQUESTERS(4), .IDXW(4)) bus16 ();
   register_write_arbiter_if #(.BITS(32), .REGISTERS(12), .REQUESTERS(4), .IDXW(4)) bus12 ();

   assign bus16.freeze = freeze;   assign bus12.freeze = freeze;
   assign bus16.req = req;         assign bus12.req = req;
   assign bus16.req_clr = req_clr; assign bus12.req_clr = req_clr;
   assign bus16.req_idx = req_idx; assign bus12.req_idx = req_idx;
   assign bus16.req_data = req_data; assign bus12.req_data = req_data;

   register_write_arbiter #(.BITS(32), .REGISTERS(16), .REQUESTERS(4), .IDXW(4)) d16 (
      .clk(clk), .clr_n(clr_n), .bus(bus16));
   register_write_arbiter #(.BITS(32), .REGISTERS(12), .REQUESTERS(4), .IDXW(4)) d12 (
      .clk(clk), .clr_n(clr_n), .bus(bus12));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain integers for pointer / last winner / cycles since reset.
   int          m_ptr, m_last, m_phase;
   logic [3:0]  e_ack, e_err12;
   logic [15:0] e_le16, e_rc16;
   logic [11:0] e_le12, e_rc12;
   logic [31:0] e_wr16, e_wr12;
   logic        e_busy;

   task automatic model_reset();
      m_ptr = 0; m_last = -1; m_phase = 0;
      e_ack = '0; e_err12 = '0; e_le16 = '0; e_rc16 = '0; e_le12 = '0; e_rc12 = '0;
      e_wr16 = '0; e_wr12 = '0; e_busy = 1'b1;
   endtask

   task automatic model_step();
      int w, i, idx;
      e_ack = '0; e_err12 = '0; e_le16 = '0; e_rc16 = '0; e_le12 = '0; e_rc12 = '0;
      if (m_phase == 0) begin
         e_rc16 = '1; e_rc12 = '1; e_busy = 1'b1; m_phase = 1;
      end else begin
         e_busy = 1'b0; m_phase = 2; w = -1;
         if (!freeze)
            for (int k = 0; k < 4; k++) begin
               i = (m_ptr + k) % 4;
               if (w < 0 && req[i] && i != m_last) w = i;
            end
         if (w >= 0) begin
            e_ack[w] = 1'b1;
            idx = int'(req_idx[w*4 +: 4]);
            if (req_clr[w]) e_rc16[idx] = 1'b1;
            else begin e_le16[idx] = 1'b1; e_wr16 = req_data[w*32 +: 32]; end
            if (idx >= 12) e_err12[w] = 1'b1;
            else if (req_clr[w]) e_rc12[idx] = 1'b1;
            else begin e_le12[idx] = 1'b1; e_wr12 = req_data[w*32 +: 32]; end
            m_ptr = (w + 1) % 4;
         end
         m_last = w;
      end
   endtask

   task automatic check_all();
      chk("ack16", 32'(bus16.ack), 32'(e_ack));
      chk("ack12", 32'(bus12.ack), 32'(e_ack));
      chk("err16", 32'(bus16.err), 32'd0);
      chk("err12", 32'(bus12.err), 32'(e_err12));
      chk("le16", 32'(bus16.load_enable), 32'(e_le16));
      chk("le12", 32'(bus12.load_enable), 32'(e_le12));
      chk("rc16", 32'(bus16.reg_clr), 32'(e_rc16));
      chk("rc12", 32'(bus12.reg_clr), 32'(e_rc12));
      chk("wr16", bus16.wr_data, e_wr16);
      chk("wr12", bus12.wr_data, e_wr12);
      chk("busy16", 32'(bus16.busy), 32'(e_busy));
      chk("busy12", 32'(bus12.busy), 32'(e_busy));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk); #1;
      check_all();
   endtask

   task automatic set_req(input int i, input logic c, input logic [3:0] idx, input logic [31:0] d);
      req[i] = 1'b1; req_clr[i] = c; req_idx[i*4 +: 4] = idx; req_data[i*32 +: 32] = d;
   endtask

   task automatic clear_inputs();
      freeze = 1'b0; req = '0; req_clr = '0; req_idx = '0; req_data = '0;
   endtask

   initial begin
      clr_n = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();

      // Reset release: one clear-all cycle, then idle.
      clr_n = 1'b1;
      cyc();
      chk("init_rc", 32'(bus16.reg_clr), 32'h0000_FFFF);
      cyc();
      chk("run_busy", 32'(bus16.busy), 32'd0);

      // Fairness with everyone requesting.
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i + 8), 32'h1000_0000 + 32'(i));
      for (int c = 0; c < 8; c++) begin
         cyc();
         chk("fair_ack", 32'(bus16.ack), 32'(1) << (c % 4));
      end
      clear_inputs();
      cyc();

      // Single write held one cycle past its ack.
      set_req(2, 1'b0, 4'd5, 32'hDEAD_BEEF);
      cyc();
      chk("single_le", 32'(bus16.load_enable), 32'h0000_0020);
      cyc();
      chk("single_noack", 32'(bus16.ack), 32'd0);
      clear_inputs();
      cyc();

      // Clear request, then an index beyond the 12-register file.
      set_req(1, 1'b1, 4'd15, 32'h5555_5555);
      cyc();
      chk("clr_rc", 32'(bus16.reg_clr), 32'h0000_8000);
      clear_inputs();
      cyc();
      set_req(1, 1'b0, 4'd13, 32'hA5A5_0013);
      cyc();
      chk("inv_err", 32'(bus12.err), 32'h2);
      chk("inv_le", 32'(bus12.load_enable), 32'd0);
      clear_inputs();
      cyc();

      // Freeze holds off grants.
      set_req(0, 1'b0, 4'd3, 32'h0000_0003);
      set_req(1, 1'b0, 4'd4, 32'h0000_0004);
      freeze = 1'b1;
      repeat (3) begin
         cyc();
         chk("frz_ack", 32'(bus16.ack), 32'd0);
      end
      freeze = 1'b0;
      cyc();
      chk("frz_rel0", 32'(bus16.ack), 32'h1);
      req[0] = 1'b0;
      cyc();
      chk("frz_rel1", 32'(bus16.ack), 32'h2);
      clear_inputs();
      cyc();

      // Randomised traffic: new requests, withdrawals, freezes.
      for (int c = 0; c < 1500; c++) begin
         freeze = ($urandom_range(0, 9) == 0);
         cyc();
         for (int i = 0; i < 4; i++) begin
            if (req[i] && e_ack[i]) req[i] = 1'b0;
            if (!req[i]) begin
               if ($urandom_range(0, 2) == 0)
                  set_req(i, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), $urandom);
            end else if ($urandom_range(0, 19) == 0) begin
               req[i] = 1'b0;
            end
         end
      end
      clear_inputs();
      cyc();

      // Reset in the ack cycle aborts the grant and replays the clear-all.
      set_req(3, 1'b0, 4'd2, 32'hCAFE_0003);
      set_req(0, 1'b0, 4'd7, 32'hCAFE_0000);
      req[0] = 1'b0;
      cyc();
      chk("pre_rst_ack", 32'(bus16.ack), 32'h8);
      clr_n = 1'b0;
      #1;
      chk("rst_ack", 32'(bus16.ack), 32'd0);
      chk("rst_le", 32'(bus16.load_enable), 32'd0);
      chk("rst_busy", 32'(bus16.busy), 32'd1);
      model_reset();
      @(posedge clk); #1;
      check_all();
      set_req(0, 1'b0, 4'd7, 32'hCAFE_0000);
      clr_n = 1'b1;
      cyc();
      chk("reinit_rc", 32'(bus16.reg_clr), 32'h0000_FFFF);
      cyc();
      chk("reinit_ack0", 32'(bus16.ack), 32'h1);
      clear_inputs();
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
